// File: rtl/imem_pkg.sv
// imem_pkg: shared types and defaults for the instruction memory and its run-time loader
package imem_pkg;
  localparam int DEF_BIT_WIDTH = 32;
  localparam int DEF_ENTRY_COUNT = 256;
  localparam int HDR_BYTES = 2;
  localparam int CHK_MOD = 256;
  localparam int CHK_WIDTH = $clog2(CHK_MOD);
  typedef enum logic [2:0] {
    S_IDLE, S_HDR_LO, S_HDR_HI, S_PAYLOAD, S_CHECK, S_DONE, S_ERR
  } imem_load_state_t;
  function automatic logic is_busy(input imem_load_state_t s);
    return s inside {S_HDR_LO, S_HDR_HI, S_PAYLOAD, S_CHECK};
  endfunction
endpackage

// File: rtl/imem_word_assembler.sv
// imem_word_assembler: packs a little-endian byte stream into words with a one-cycle valid strobe
module imem_word_assembler
  import imem_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 byte_en,
  input  logic [7:0]           byte_data,
  output logic [BIT_WIDTH-1:0] word,
  output logic                 word_valid,
  output logic                 word_last
);
  localparam int BYTES = BIT_WIDTH / 8;
  localparam int CW = BYTES > 1 ? $clog2(BYTES) : 1;
  logic [CW-1:0] cnt;
  logic [BIT_WIDTH-1:0] sh, sh_n;
  // newest byte enters at the top so the first byte ends up in bits [7:0]
  assign sh_n = BIT_WIDTH'({byte_data, sh} >> 8);
  assign word_last = byte_en && cnt == CW'(BYTES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      sh <= '0;
      word <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= word_last;
      if (clear) cnt <= '0;
      else if (byte_en) begin
        sh <= sh_n;
        cnt <= word_last ? '0 : cnt + 1'b1;
      end
      if (word_last) word <= sh_n;
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: parses a length-prefixed, checksummed byte stream into sequential instruction memory writes
module imem_loader
  import imem_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int ENTRY_COUNT = DEF_ENTRY_COUNT,
  parameter int ADDR_WIDTH = $clog2((BIT_WIDTH / 8) * ENTRY_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_address,
  output logic [BIT_WIDTH-1:0]  wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int BYTES = BIT_WIDTH / 8;
  imem_load_state_t state, state_n;
  logic accept, start_ok, bad_len, word_last;
  logic [7:0] count_lo;
  logic [15:0] n_words;
  logic [ADDR_WIDTH:0] pay_cnt;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [CHK_WIDTH-1:0] sum, sum_n;
  assign accept = byte_valid && byte_ready;
  assign start_ok = start && !is_busy(state);
  assign n_words = {byte_data, count_lo};
  assign bad_len = n_words == 16'd0 || 32'(n_words) > ENTRY_COUNT;
  assign sum_n = sum + byte_data;
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: state_n = start ? S_HDR_LO : state;
      S_HDR_LO:  state_n = accept ? S_HDR_HI : state;
      S_HDR_HI:  state_n = !accept ? state : bad_len ? S_ERR : S_PAYLOAD;
      S_PAYLOAD: state_n = accept && pay_cnt == (ADDR_WIDTH + 1)'(1) ? S_CHECK : state;
      S_CHECK:   state_n = !accept ? state : sum_n == '0 ? S_DONE : S_ERR;
      default:   state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      byte_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      count_lo <= '0;
      pay_cnt <= '0;
      next_addr <= '0;
      wr_address <= '0;
      sum <= '0;
    end else begin
      state <= state_n;
      byte_ready <= is_busy(state_n);
      busy <= is_busy(state_n);
      done <= state_n == S_DONE;
      error <= state_n == S_ERR;
      if (start_ok) begin
        pay_cnt <= '0;
        next_addr <= '0;
        sum <= '0;
      end
      if (accept && state == S_HDR_LO) count_lo <= byte_data;
      if (accept && state == S_HDR_HI) pay_cnt <= (ADDR_WIDTH + 1)'(32'(n_words) * BYTES);
      if (accept && state == S_PAYLOAD) begin
        pay_cnt <= pay_cnt - 1'b1;
        sum <= sum_n;
      end
      // address is latched with the completing byte so it is valid alongside wr_en
      if (word_last) begin
        wr_address <= next_addr;
        next_addr <= next_addr + ADDR_WIDTH'(BYTES);
      end
    end
  imem_word_assembler #(.BIT_WIDTH(BIT_WIDTH)) u_asm (
    .clk(clk),
    .rst_n(rst_n),
    .clear(start_ok),
    .byte_en(accept && state == S_PAYLOAD),
    .byte_data(byte_data),
    .word(wr_data),
    .word_valid(wr_en),
    .word_last(word_last)
  );
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized loads checked against a stream-level reference model
module tb_imem_loader;
  logic clk = 0, rst_n, start, byte_valid, byte_ready, wr_en, busy, done, error;
  logic [7:0] byte_data;
  logic [9:0] wr_address;
  logic [31:0] wr_data;
  int tests = 0, fails = 0, ready_drops = 0;
  logic [9:0] got_a[$];
  logic [31:0] got_d[$];
  logic [7:0] fixed_pl[$] = '{8'h13, 8'h05, 8'h10, 8'h00};

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      got_a.push_back(wr_address);
      got_d.push_back(wr_data);
    end
    if (busy && !byte_ready) ready_drops++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  // called at a negedge; returns at the negedge following the accepting edge
  task automatic send(input logic [7:0] b);
    int n = 0;
    byte_valid = 1;
    byte_data = b;
    while (!byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      tests++;
      assert (byte_ready === 1'b1) else begin
        fails++;
        $error("FAIL send_timeout observed=%0b expected=1", byte_ready);
      end
    end
    @(negedge clk);
    byte_valid = 0;
  endtask

  task automatic run_load(input int n, input bit fixed, input bit corrupt, input bit gaps, input bit inject);
    logic [7:0] pl[$];
    logic [7:0] s = 0, ck, b;
    logic [31:0] w;
    got_a.delete();
    got_d.delete();
    ready_drops = 0;
    for (int i = 0; i < n * 4; i++) begin
      b = fixed ? fixed_pl[i] : 8'($urandom);
      pl.push_back(b);
      s += b;
    end
    ck = 8'(0 - s);
    if (corrupt) ck ^= 8'h01;
    pulse_start();
    chk("busy_after_start", busy, 1);
    chk("flags_clear_after_start", {done, error}, 0);
    send(8'(n));
    send(8'(n >> 8));
    for (int i = 0; i < n * 4; i++) begin
      if (gaps) repeat ($urandom_range(1, 3)) @(negedge clk);
      if (inject && i == 2) pulse_start();
      send(pl[i]);
    end
    chk("wr_en_on_check_entry", wr_en, 1);
    send(ck);
    chk("done", done, !corrupt);
    chk("error", error, corrupt);
    chk("idle_ready_busy", {byte_ready, busy}, 0);
    chk("write_count", got_a.size(), n);
    for (int k = 0; k < n && k < got_a.size(); k++) begin
      w = {pl[4*k+3], pl[4*k+2], pl[4*k+1], pl[4*k]};
      chk($sformatf("addr[%0d]", k), got_a[k], 4 * k);
      chk($sformatf("data[%0d]", k), got_d[k], w);
    end
    chk("ready_never_dropped", ready_drops, 0);
  endtask

  initial begin
    rst_n = 0;
    start = 0;
    byte_valid = 0;
    byte_data = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {byte_ready, wr_en, busy, done, error, wr_address, wr_data}, 0);
    rst_n = 1;
    @(negedge clk);
    byte_valid = 1;
    byte_data = 8'h55;
    repeat (3) @(negedge clk);
    byte_valid = 0;
    chk("idle_ignores_bytes", {byte_ready, busy, wr_en}, 0);

    run_load(1, 1, 0, 0, 0);
    chk("first_word_value", got_d.size() > 0 ? got_d[0] : 32'hx, 32'h00100513);
    run_load(3, 0, 0, 0, 0);

    got_a.delete();
    pulse_start();
    send(8'h00);
    send(8'h00);
    chk("len0_error", {error, done, byte_ready, busy}, 4'b1000);
    pulse_start();
    send(8'h01);
    send(8'h01);
    chk("len257_error", {error, done, byte_ready, busy}, 4'b1000);
    chk("bad_len_no_writes", got_a.size(), 0);

    run_load(2, 0, 1, 0, 0);
    pulse_start();
    chk("start_clears_error", {error, done, busy}, 3'b001);

    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    got_a.delete();
    pulse_start();
    send(8'h02);
    send(8'h00);
    send(8'($urandom));
    send(8'($urandom));
    rst_n = 0;
    #1;
    chk("reset_mid_load", {byte_ready, wr_en, busy, done, error, wr_address, wr_data}, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (4) @(negedge clk);
    chk("reset_no_writes", got_a.size(), 0);
    run_load(3, 0, 0, 0, 0);

    run_load(4, 0, 0, 1, 1);
    for (int r = 0; r < 4; r++) run_load($urandom_range(1, 8), 0, r == 2, r[0], r[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that writes the instruction memory image at run time, replacing the file preload for on-board bring-up. It sits between a byte source (UART receiver or debug bridge) and the write port of the instruction store. It parses a length header, assembles little-endian words, and issues sequential word writes at byte addresses. A checksum trailer validates the image.

## Interface
- BIT_WIDTH, 32, word width written to instruction memory; multiple of 8
- ENTRY_COUNT, 256, number of words in instruction memory
- ADDR_WIDTH, $clog2((BIT_WIDTH/8)*ENTRY_COUNT), byte-address width
- clk  input  1  single clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a load when idle
- byte_valid  input  1  byte_data holds a byte
- byte_data  input  8  stream byte
- byte_ready  output  1  loader accepts byte this cycle
- wr_en  output  1  one-cycle word write strobe
- wr_address  output  ADDR_WIDTH  byte address of the word, low 2 bits always 0
- wr_data  output  BIT_WIDTH  assembled word
- busy  output  1  load in progress
- done  output  1  sticky; load finished with good checksum
- error  output  1  sticky; bad length or checksum mismatch

## Operation
- A byte is accepted when byte_valid && byte_ready.
- Stream format: COUNT_LO, COUNT_HI (16-bit word count N, little-endian), then N*(BIT_WIDTH/8) payload bytes, then one CHECK byte.
- FSM states and transitions:
  - IDLE: goes to HDR_LO on start.
  - HDR_LO: goes to HDR_HI on accept.
  - HDR_HI: on accept, goes to ERR if N==0 or N>ENTRY_COUNT, else to PAYLOAD.
  - PAYLOAD: goes to CHECK after the last payload byte is accepted.
  - CHECK: on accept, goes to DONE if (sum of payload bytes + CHECK) mod 256 == 0, else to ERR.
  - DONE and ERR: go to HDR_LO on start.
- Words are little-endian: the first byte goes to wr_data[7:0].
- Word k is written at wr_address = 4*k, with k counting from 0 and no wrap; the length check guarantees k < ENTRY_COUNT.
- Header bytes are not included in the checksum.
- byte_ready is 1 only in HDR_LO, HDR_HI, PAYLOAD and CHECK.
- busy is 1 in the same states.
- done is 1 only in DONE; error is 1 only in ERR. Both clear on the next accepted start.
- A start pulse while busy is ignored.
- Reset mid-load aborts the load with no further writes. Words already written remain in memory.

## Timing
- Reset values:
  - FSM state: IDLE
  - byte_ready, wr_en, busy, done, error: 0
  - wr_address, wr_data: 0
  - internal byte counter, word counter, checksum: 0
- start is sampled while in IDLE, DONE or ERR; byte_ready rises the following cycle.
- wr_en pulses exactly one cycle, in the cycle after the last byte of a word is accepted. wr_address and wr_data are valid in that cycle and hold until the next write.
- Full-rate streaming (one byte per cycle) is supported with no backpressure. byte_ready never drops mid-payload.
- The final payload word's wr_en occurs in the cycle the FSM enters CHECK, so the write is not blocked by the trailer.
- done or error is asserted the cycle after the CHECK byte is accepted; for a bad length, error is asserted the cycle after the HDR_HI byte.
- byte_valid in IDLE, DONE or ERR is ignored; no bytes are consumed.

## Structure
- Package imem_pkg holds:
  - state enum imem_load_state_t
  - header byte count (2) and checksum modulus
  - shared BIT_WIDTH/ENTRY_COUNT defaults, reused by the memory and the loader
- One sub-module: imem_word_assembler. It shifts in bytes, counts the bytes within a word, and emits word plus a one-cycle word_valid. The FSM, address counter and checksum live in the top.

## Test plan
- Load N=1, payload 13 05 10 00, CHECK 0xD8 -> one wr_en with wr_address 0x0 and wr_data 0x00100513; done=1 and error=0 one cycle after CHECK.
- Load N=3 with byte_valid held high every cycle -> exactly 3 wr_en pulses at addresses 0x0, 0x4, 0x8; byte_ready stays high throughout; done=1.
- Header N=0, then N=ENTRY_COUNT+1 (257) -> error=1 after HDR_HI, zero wr_en pulses, byte_ready=0.
- N=2 with a wrong CHECK byte (correct value XOR 0x01) -> 2 writes occur, then error=1 and done=0; a new start clears error.
- rst_n asserted low after 2 payload bytes -> all outputs 0 immediately with no wr_en; a following full load succeeds from address 0x0.
- start pulse during PAYLOAD, with byte_valid gaps of 1-3 cycles -> start is ignored; words still assemble correctly and addresses do not skip.
